// File: rtl/abr_reg_bank_arb_if.sv
// rtl/abr_reg_bank_arb_if.sv - requester fabric and register bank signals of the CSR bank arbiter
interface abr_reg_bank_arb_if #(
    parameter int NumReq  = 2,
    parameter int NumRegs = 16,
    parameter int AW      = 6,
    parameter int DW      = 32
);
    logic [NumReq-1:0]      req_i;
    logic [NumReq-1:0]      gnt_o;
    logic [NumReq*AW-1:0]   addr_i;
    logic [NumReq-1:0]      we_i;
    logic [NumReq*DW-1:0]   wdata_i;
    logic [NumReq-1:0]      rsp_valid_o;
    logic [NumReq-1:0]      rsp_ready_i;
    logic [DW-1:0]          rsp_rdata_o;
    logic                   rsp_err_o;
    logic [NumRegs-1:0]     reg_we_o;
    logic [NumRegs-1:0]     reg_re_o;
    logic [DW-1:0]          reg_wd_o;
    logic [NumRegs*DW-1:0]  reg_qs_i;
    logic                   busy_o;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, rsp_ready_i, reg_qs_i,
        output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               reg_we_o, reg_re_o, reg_wd_o, busy_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, rsp_ready_i, reg_qs_i,
        input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               reg_we_o, reg_re_o, reg_wd_o, busy_o
    );
endinterface

// File: rtl/abr_reg_bank_arb.sv
// rtl/abr_reg_bank_arb.sv - round-robin arbiter and access sequencer for a shared subreg CSR bank
module abr_reg_bank_arb #(
    parameter int                 NumReq  = 2,
    parameter int                 NumRegs = 16,
    parameter int                 AW      = 6,
    parameter int                 DW      = 32,
    parameter logic [NumRegs-1:0] RoMask  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    abr_reg_bank_arb_if.slave  bus
);
    localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       win_q;
    logic [AW-1:0]       addr_q;
    logic                we_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       rdata_q;
    logic                err_q;

    logic [IW-1:0]       arb_idx;
    logic                arb_found;
    logic [AW-1:0]       arb_addr;
    logic                arb_we;
    logic [DW-1:0]       arb_wdata;

    logic [NumRegs-1:0]  dec;
    logic [DW-1:0]       qs_sel;
    logic                acc_err;
    logic                rsp_done;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
        return IW'((int'(p) + k) % NumReq);
    endfunction

    // First requester at or above the pointer wins, wrapping at NumReq.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (!arb_found && bus.req_i[rr_idx(ptr_q, k)]) begin
                arb_found = 1'b1;
                arb_idx   = rr_idx(ptr_q, k);
            end
        end
        arb_addr  = '0;
        arb_we    = 1'b0;
        arb_wdata = '0;
        for (int r = 0; r < NumReq; r++) begin
            if (IW'(r) == arb_idx) begin
                arb_addr  = bus.addr_i[r*AW +: AW];
                arb_we    = bus.we_i[r];
                arb_wdata = bus.wdata_i[r*DW +: DW];
            end
        end
    end

    // Full-width compare so addresses above NumRegs never alias onto a mapped register.
    always_comb begin
        dec    = '0;
        qs_sel = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (32'(addr_q) == i) begin
                dec[i] = 1'b1;
                qs_sel = bus.reg_qs_i[i*DW +: DW];
            end
        end
        acc_err = !(|dec) | (we_q & |(dec & RoMask));
    end

    assign rsp_done = (state_q == RESP) && bus.rsp_ready_i[win_q];

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        bus.gnt_o       = '0;
        bus.rsp_valid_o = '0;
        bus.rsp_rdata_o = '0;
        bus.rsp_err_o   = 1'b0;
        bus.reg_we_o    = '0;
        bus.reg_re_o    = '0;
        bus.reg_wd_o    = '0;
        bus.busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    bus.gnt_o[arb_idx] = 1'b1;
                    state_d            = ACCESS;
                end
            end
            ACCESS: begin
                bus.busy_o = 1'b1;
                if (!acc_err && we_q) begin
                    bus.reg_we_o = dec;
                    bus.reg_wd_o = wdata_q;
                end else if (!acc_err) begin
                    bus.reg_re_o = dec;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.busy_o             = 1'b1;
                bus.rsp_valid_o[win_q] = 1'b1;
                bus.rsp_rdata_o        = rdata_q;
                bus.rsp_err_o          = err_q;
                if (rsp_done) begin
                    state_d = IDLE;
                    ptr_d   = (win_q == IW'(NumReq - 1)) ? '0 : win_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == IDLE && arb_found) begin
                win_q   <= arb_idx;
                addr_q  <= arb_addr;
                we_q    <= arb_we;
                wdata_q <= arb_wdata;
            end
            // Read data is sampled alongside the re pulse, so RC fields return their pre-clear value.
            if (state_q == ACCESS) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || we_q) ? '0 : qs_sel;
            end
            if (rsp_done) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    a_gnt_onehot:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.gnt_o));
    a_rsp_onehot:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.rsp_valid_o));
    a_we_onehot:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.reg_we_o));
    a_re_onehot:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.reg_re_o));
    a_we_re_excl:   assert property (@(posedge clk_i) disable iff (rst_i) !((|bus.reg_we_o) && (|bus.reg_re_o)));
endmodule

// File: tb/tb_abr_reg_bank_arb.sv
// tb/tb_abr_reg_bank_arb.sv - directed self-checking bench for abr_reg_bank_arb
module tb_abr_reg_bank_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    abr_reg_bank_arb_if #(.NumReq(2), .NumRegs(16), .AW(6), .DW(32)) bus ();

    abr_reg_bank_arb #(
        .NumReq(2), .NumRegs(16), .AW(6), .DW(32), .RoMask(16'h0004)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b00)       begin n_err++; $display("FAIL rst_gnt: got %b want 00", bus.gnt_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b want 00", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h0)  begin n_err++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0)     begin n_err++; $display("FAIL rst_err: got %b want 0", bus.rsp_err_o); end
        n_cmp++; if (bus.reg_we_o !== 16'h0)     begin n_err++; $display("FAIL rst_we: got %h want 0", bus.reg_we_o); end
        n_cmp++; if (bus.reg_re_o !== 16'h0)     begin n_err++; $display("FAIL rst_re: got %h want 0", bus.reg_re_o); end
        n_cmp++; if (bus.reg_wd_o !== 32'h0)     begin n_err++; $display("FAIL rst_wd: got %h want 0", bus.reg_wd_o); end
        n_cmp++; if (bus.busy_o !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read();
        @(negedge clk);
        bus.addr_i[0 +: 6] = 6'd3; bus.we_i[0] = 1'b0; bus.req_i = 2'b01;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b want 01", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_re_o !== 16'h0008) begin n_err++; $display("FAIL rd_re: got %h want 0008", bus.reg_re_o); end
        n_cmp++; if (bus.reg_we_o !== 16'h0000) begin n_err++; $display("FAIL rd_we: got %h want 0000", bus.reg_we_o); end
        n_cmp++; if (bus.busy_o !== 1'b1)       begin n_err++; $display("FAIL rd_busy: got %b want 1", bus.busy_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b01)        begin n_err++; $display("FAIL rd_valid: got %b want 01", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL rd_rdata: got %h want a5a50001", bus.rsp_rdata_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0)           begin n_err++; $display("FAIL rd_err: got %b want 0", bus.rsp_err_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b00)  begin n_err++; $display("FAIL rd_clr_valid: got %b want 00", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h0)  begin n_err++; $display("FAIL rd_clr_rdata: got %h want 0", bus.rsp_rdata_o); end
        n_cmp++; if (bus.busy_o !== 1'b0)        begin n_err++; $display("FAIL rd_clr_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_write();
        bus.addr_i[6 +: 6] = 6'd5; bus.we_i[1] = 1'b1; bus.wdata_i[32 +: 32] = 32'hDEAD_BEEF; bus.req_i = 2'b10;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_we_o !== 16'h0020)      begin n_err++; $display("FAIL wr_we: got %h want 0020", bus.reg_we_o); end
        n_cmp++; if (bus.reg_wd_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_wd: got %h want deadbeef", bus.reg_wd_o); end
        n_cmp++; if (bus.reg_re_o !== 16'h0000)      begin n_err++; $display("FAIL wr_re: got %h want 0000", bus.reg_re_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.reg_we_o !== 16'h0000)  begin n_err++; $display("FAIL wr_we_1cyc: got %h want 0000", bus.reg_we_o); end
        n_cmp++; if (bus.reg_wd_o !== 32'h0)     begin n_err++; $display("FAIL wr_wd_1cyc: got %h want 0", bus.reg_wd_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b10)  begin n_err++; $display("FAIL wr_valid: got %b want 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h0)  begin n_err++; $display("FAIL wr_rdata: got %h want 0", bus.rsp_rdata_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b0)     begin n_err++; $display("FAIL wr_err: got %b want 0", bus.rsp_err_o); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        @(negedge clk);
        bus.addr_i[0 +: 6] = 6'd3; bus.we_i[0] = 1'b0;
        bus.addr_i[6 +: 6] = 6'd4; bus.we_i[1] = 1'b0;
        bus.req_i = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_gnt = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            n_cmp++; if (bus.gnt_o !== exp_gnt) begin n_err++; $display("FAIL fair_gnt_c%0d: got %b want %b", c, bus.gnt_o, exp_gnt); end
        end
        @(negedge clk);
        bus.req_i = 2'b00;
    endtask

    task automatic test_errors();
        @(negedge clk);
        bus.addr_i[0 +: 6] = 6'd16; bus.we_i[0] = 1'b0; bus.req_i = 2'b01;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL unm_gnt: got %b want 01", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_re_o !== 16'h0) begin n_err++; $display("FAIL unm_re: got %h want 0", bus.reg_re_o); end
        n_cmp++; if (bus.reg_we_o !== 16'h0) begin n_err++; $display("FAIL unm_we: got %h want 0", bus.reg_we_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL unm_valid: got %b want 01", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b1)    begin n_err++; $display("FAIL unm_err: got %b want 1", bus.rsp_err_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL unm_rdata: got %h want 0", bus.rsp_rdata_o); end
        @(negedge clk);
        bus.addr_i[6 +: 6] = 6'd2; bus.we_i[1] = 1'b1; bus.wdata_i[32 +: 32] = 32'h1234_5678; bus.req_i = 2'b10;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL ro_gnt: got %b want 10", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_we_o !== 16'h0) begin n_err++; $display("FAIL ro_we: got %h want 0", bus.reg_we_o); end
        n_cmp++; if (bus.reg_re_o !== 16'h0) begin n_err++; $display("FAIL ro_re: got %h want 0", bus.reg_re_o); end
        n_cmp++; if (bus.reg_wd_o !== 32'h0) begin n_err++; $display("FAIL ro_wd: got %h want 0", bus.reg_wd_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL ro_valid: got %b want 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_err_o !== 1'b1)    begin n_err++; $display("FAIL ro_err: got %b want 1", bus.rsp_err_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h0) begin n_err++; $display("FAIL ro_rdata: got %h want 0", bus.rsp_rdata_o); end
        bus.we_i = 2'b00;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.rsp_ready_i = 2'b00;
        bus.addr_i[0 +: 6] = 6'd3; bus.we_i[0] = 1'b0; bus.req_i = 2'b01;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL bp_gnt0: got %b want 01", bus.gnt_o); end
        @(negedge clk);
        bus.addr_i[6 +: 6] = 6'd7; bus.we_i[1] = 1'b0; bus.req_i = 2'b10;
        #1;
        n_cmp++; if (bus.reg_re_o !== 16'h0008) begin n_err++; $display("FAIL bp_re: got %h want 0008", bus.reg_re_o); end
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) bus.rsp_ready_i = 2'b10;
            if (c == 7) bus.rsp_ready_i = 2'b01;
            #1;
            n_cmp++; if (bus.rsp_valid_o !== 2'b01)        begin n_err++; $display("FAIL bp_valid_c%0d: got %b want 01", c, bus.rsp_valid_o); end
            n_cmp++; if (bus.rsp_rdata_o !== 32'hA5A5_0001) begin n_err++; $display("FAIL bp_rdata_c%0d: got %h want a5a50001", c, bus.rsp_rdata_o); end
            n_cmp++; if (bus.gnt_o !== 2'b00)              begin n_err++; $display("FAIL bp_nognt_c%0d: got %b want 00", c, bus.gnt_o); end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL bp_gnt1: got %b want 10", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_re_o !== 16'h0080) begin n_err++; $display("FAIL bp_re1: got %h want 0080", bus.reg_re_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b10)        begin n_err++; $display("FAIL bp_valid1: got %b want 10", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== 32'h1000_0007) begin n_err++; $display("FAIL bp_rdata1: got %h want 10000007", bus.rsp_rdata_o); end
        @(negedge clk);
        bus.rsp_ready_i = 2'b11;
        #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL bp_hold1: got %b want 10", bus.rsp_valid_o); end
        @(negedge clk); #1;
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL bp_done1: got %b want 00", bus.rsp_valid_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.addr_i[0 +: 6] = 6'd0; bus.we_i[0] = 1'b0; bus.req_i = 2'b01;
        @(negedge clk);
        bus.req_i = 2'b00;
        repeat (2) @(negedge clk);
        bus.addr_i[6 +: 6] = 6'd6; bus.we_i[1] = 1'b1; bus.wdata_i[32 +: 32] = 32'h0BAD_F00D; bus.req_i = 2'b10;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL rm_gnt: got %b want 10", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        #1;
        n_cmp++; if (bus.reg_we_o !== 16'h0040) begin n_err++; $display("FAIL rm_we_pre: got %h want 0040", bus.reg_we_o); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.reg_we_o !== 16'h0)     begin n_err++; $display("FAIL rm_we: got %h want 0", bus.reg_we_o); end
        n_cmp++; if (bus.reg_wd_o !== 32'h0)     begin n_err++; $display("FAIL rm_wd: got %h want 0", bus.reg_wd_o); end
        n_cmp++; if (bus.busy_o !== 1'b0)        begin n_err++; $display("FAIL rm_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b00)  begin n_err++; $display("FAIL rm_valid: got %b want 00", bus.rsp_valid_o); end
        @(negedge clk);
        rst = 1'b0;
        bus.we_i = 2'b00; bus.req_i = 2'b11;
        #1;
        n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL rm_gnt_after: got %b want 01", bus.gnt_o); end
        @(negedge clk);
        bus.req_i = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.req_i       = '0;
        bus.addr_i      = '0;
        bus.we_i        = '0;
        bus.wdata_i     = '0;
        bus.rsp_ready_i = 2'b11;
        for (int i = 0; i < 16; i++) bus.reg_qs_i[i*32 +: 32] = 32'h1000_0000 | 32'(i);
        bus.reg_qs_i[3*32 +: 32] = 32'hA5A5_0001;
        test_reset();
        test_read();
        test_write();
        test_fairness();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
